// File: rtl/fastica_pkg.sv
// Shared constants, types and the saturation helper for the FastICA
// fixed-point update datapath. All data is signed Q6.20.
package fastica_pkg;

  localparam int DW        = 26;
  localparam int FRAC      = 20;
  localparam int N_SAMPLES = 128;
  localparam int LOG2_N    = 7;
  localparam int ACCW      = 40;

  // Derived widths: full product, four-term product sum, 3*w headroom.
  localparam int PW = 2 * DW;
  localparam int SW = PW + 2;
  localparam int TW = DW + 3;
  localparam int CW = LOG2_N + 1;

  localparam logic signed [63:0] DW_MAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
  localparam logic signed [63:0] DW_MIN = -(64'sd1 <<< (DW - 1));

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DRAIN = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic                 ovf;
    logic signed [DW-1:0] val;
  } sat_t;

  // Clamp a wide signed value into DW bits and report whether it clamped.
  function automatic sat_t sat_dw(input logic signed [63:0] v);
    sat_t r;
    if (v > DW_MAX) begin
      r.ovf = 1'b1;
      r.val = DW_MAX[DW-1:0];
    end else if (v < DW_MIN) begin
      r.ovf = 1'b1;
      r.val = DW_MIN[DW-1:0];
    end else begin
      r.ovf = 1'b0;
      r.val = v[DW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ica_proj_cube.sv
// Four-stage projection and cube pipeline: y = w.z, then y^3, with z
// carried alongside so the accumulator sees z and y^3 of the same sample.
// Each stage carries a valid bit; the sat bit travels with its sample and
// is the OR of every clamp that sample hit on the way through.
module ica_proj_cube
  import fastica_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic signed [DW-1:0] w [4],
  input  logic signed [DW-1:0] z [4],
  output logic signed [DW-1:0] z_dly [4],
  output logic signed [DW-1:0] y3,
  output logic                 y3_valid,
  output logic                 y3_sat,
  output logic                 active
);

  logic signed [PW-1:0] s1_p [4];
  logic signed [DW-1:0] s1_z [4];
  logic signed [DW-1:0] s2_z [4];
  logic signed [DW-1:0] s3_z [4];
  logic signed [DW-1:0] s4_z [4];
  logic                 s1_v, s2_v, s3_v, s4_v;
  logic                 s2_sat, s3_sat, s4_sat;
  logic signed [DW-1:0] s2_y, s3_y, s3_y2, s4_y3;

  logic signed [SW-1:0] psum, psum_sh;
  logic signed [PW-1:0] yy, yy_sh, yyy, yyy_sh;
  sat_t                 y_c, y2_c, y3_c;

  // Stage arithmetic between registers: sum-and-shift, square, cube.
  always_comb begin
    psum    = SW'(s1_p[0]) + SW'(s1_p[1]) + SW'(s1_p[2]) + SW'(s1_p[3]);
    psum_sh = psum >>> FRAC;
    y_c     = sat_dw(64'(psum_sh));
    yy      = PW'(s2_y) * PW'(s2_y);
    yy_sh   = yy >>> FRAC;
    y2_c    = sat_dw(64'(yy_sh));
    yyy     = PW'(s3_y2) * PW'(s3_y);
    yyy_sh  = yyy >>> FRAC;
    y3_c    = sat_dw(64'(yyy_sh));
  end

  // Pipeline registers S1..S4 with per-stage valid and carried sat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        s1_p[i] <= '0;
        s1_z[i] <= '0;
        s2_z[i] <= '0;
        s3_z[i] <= '0;
        s4_z[i] <= '0;
      end
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s3_v   <= 1'b0;
      s4_v   <= 1'b0;
      s2_sat <= 1'b0;
      s3_sat <= 1'b0;
      s4_sat <= 1'b0;
      s2_y   <= '0;
      s3_y   <= '0;
      s3_y2  <= '0;
      s4_y3  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        s1_p[i] <= PW'(z[i]) * PW'(w[i]);
        s1_z[i] <= z[i];
        s2_z[i] <= s1_z[i];
        s3_z[i] <= s2_z[i];
        s4_z[i] <= s3_z[i];
      end
      s1_v   <= valid;
      s2_v   <= s1_v;
      s3_v   <= s2_v;
      s4_v   <= s3_v;
      s2_y   <= y_c.val;
      s2_sat <= y_c.ovf;
      s3_y   <= s2_y;
      s3_y2  <= y2_c.val;
      s3_sat <= s2_sat | y2_c.ovf;
      s4_y3  <= y3_c.val;
      s4_sat <= s3_sat | y3_c.ovf;
    end
  end

  assign z_dly    = s4_z;
  assign y3       = s4_y3;
  assign y3_valid = s4_v;
  assign y3_sat   = s4_sat;
  assign active   = s1_v | s2_v | s3_v | s4_v;

endmodule

// File: rtl/ica_fixedpoint_update.sv
// FastICA kurtosis fixed-point update: accumulates z*(w.z)^3 over a block
// of N_SAMPLES whitened samples and emits mean(z*y^3) - 3*w (un-normalised).
//
// Sample handshake: there is no back-pressure. A sample is taken on every
// rising clk edge where z_valid is high and the block is in ACCUM; samples
// offered in any other state are dropped. The block leaves ACCUM on the
// edge that takes the N_SAMPLES-th sample, so surplus samples never count.
module ica_fixedpoint_update
  import fastica_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [DW-1:0] w1_in,
  input  logic signed [DW-1:0] w2_in,
  input  logic signed [DW-1:0] w3_in,
  input  logic signed [DW-1:0] w4_in,
  input  logic                 z_valid,
  input  logic signed [DW-1:0] z1_in,
  input  logic signed [DW-1:0] z2_in,
  input  logic signed [DW-1:0] z3_in,
  input  logic signed [DW-1:0] z4_in,
  output logic                 busy,
  output logic                 done,
  output logic signed [DW-1:0] w1_out,
  output logic signed [DW-1:0] w2_out,
  output logic signed [DW-1:0] w3_out,
  output logic signed [DW-1:0] w4_out,
  output logic                 sat_flag,
  output logic [2:0]           state_dbg
);

  localparam logic [CW-1:0] CNT_LAST = CW'(N_SAMPLES - 1);

  state_t                 state;
  logic [CW-1:0]          count;
  logic signed [DW-1:0]   w_lat [4];
  logic signed [DW-1:0]   w_res [4];
  logic signed [ACCW-1:0] acc [4];
  logic                   acc_v;

  logic signed [DW-1:0]   z_vec [4];
  logic signed [DW-1:0]   pz [4];
  logic signed [DW-1:0]   py3;
  logic                   pv, psat, pipe_active, take;

  logic signed [PW-1:0]   zy [4];
  logic signed [PW-1:0]   zy_sh [4];
  logic signed [ACCW-1:0] term [4];
  logic signed [ACCW-1:0] acc_sh [4];
  sat_t                   m_c [4];
  logic signed [DW-1:0]   m_val [4];
  logic signed [TW-1:0]   w3x [4];
  logic signed [TW-1:0]   diff [4];
  sat_t                   wn_c [4];
  logic                   fin_ovf;

  assign z_vec = '{z1_in, z2_in, z3_in, z4_in};
  assign take  = (state == ACCUM) && z_valid;

  ica_proj_cube u_proj (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (take),
    .w        (w_lat),
    .z        (z_vec),
    .z_dly    (pz),
    .y3       (py3),
    .y3_valid (pv),
    .y3_sat   (psat),
    .active   (pipe_active)
  );

  // Accumulator term z*y^3 and the end-of-block mean minus 3*w.
  always_comb begin
    fin_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      zy[i]     = PW'(pz[i]) * PW'(py3);
      zy_sh[i]  = zy[i] >>> FRAC;
      term[i]   = ACCW'(zy_sh[i]);
      acc_sh[i] = acc[i] >>> LOG2_N;
      m_c[i]    = sat_dw(64'(acc_sh[i]));
      m_val[i]  = m_c[i].val;
      w3x[i]    = (TW'(w_lat[i]) <<< 1) + TW'(w_lat[i]);
      diff[i]   = TW'(m_val[i]) - w3x[i];
      wn_c[i]   = sat_dw(64'(diff[i]));
      fin_ovf   = fin_ovf | m_c[i].ovf | wn_c[i].ovf;
    end
  end

  // Control FSM plus accumulators, result registers and sticky saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
      acc_v    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        w_lat[i] <= '0;
        w_res[i] <= '0;
        acc[i]   <= '0;
      end
    end else begin
      done  <= 1'b0;
      acc_v <= pv;
      if (pv) begin
        for (int i = 0; i < 4; i++) acc[i] <= acc[i] + term[i];
        if (psat) sat_flag <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            w_lat    <= '{w1_in, w2_in, w3_in, w4_in};
            for (int i = 0; i < 4; i++) acc[i] <= '0;
            sat_flag <= 1'b0;
            count    <= '0;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (z_valid) begin
            count <= count + CW'(1);
            if (count == CNT_LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          // acc_v covers the edge on which the last term lands in acc.
          if (!pipe_active && !acc_v) state <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < 4; i++) w_res[i] <= wn_c[i].val;
          if (fin_ovf) sat_flag <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign w1_out    = w_res[0];
  assign w2_out    = w_res[1];
  assign w3_out    = w_res[2];
  assign w4_out    = w_res[3];
  assign state_dbg = state;

endmodule

// File: doc/ica_fixedpoint_update.md
Name: ica_fixedpoint_update

Overview:
- Downstream consumer of the whitened-sample buffer (RAM stage).
- The buffer streams 128 four-channel Z samples, one per cycle. For each sample this block computes the projection y = w·z and the contrast term g(y) = y^3, then accumulates z_i·y^3 over all samples.
- When the last sample has been accumulated, it emits the un-normalised FastICA kurtosis update w_new = mean(z·y^3) − 3·w.
- Normalisation and decorrelation of w_new are handled by a later block.

Parameters:
- DW, 26: signed data width of Z, w and y.
- FRAC, 20: fractional bits. Q6.20 format, so 1.0 = 1048576.
- N_SAMPLES, 128: samples per update. Must be a power of two.
- LOG2_N, 7: log2(N_SAMPLES).
- ACCW, 40: accumulator width.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latches w1_in..w4_in and arms the block
- w1_in..w4_in  in  26 each  signed current weight vector, Q6.20
- z_valid  in  1  a Z sample is present this cycle
- z1_in..z4_in  in  26 each  signed whitened sample, Q6.20
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse; w*_out valid from this cycle on
- w1_out..w4_out  out  26 each  signed updated weight, Q6.20; held until the next done
- sat_flag  out  1  sticky; set on any saturation during the current update

Behaviour:
- Interface (already decided): one clock (clk); reset (rst_n) is asynchronous and active-low.
- Reset state: state=IDLE, busy=0, done=0, w*_out=0, sat_flag=0, sample count=0, accumulators=0, pipeline valids=0.
- Reset asserted mid-operation aborts immediately to the reset state. No partial result is produced.
- States:
  - IDLE: on start, latch w, clear accumulators and sat_flag, count=0 → ACCUM.
  - ACCUM: each z_valid enters the pipe and increments count. When count reaches N_SAMPLES → DRAIN.
  - DRAIN: wait until the pipeline valids are empty → FINAL.
  - FINAL: one cycle computing w_new → DONE.
  - DONE: pulse done, register w*_out → IDLE.
- Ignored inputs:
  - z_valid in IDLE, DRAIN, FINAL or DONE is ignored. Surplus samples are never accumulated.
  - start while busy is ignored.
- z_valid may have gaps. Only valid samples count, and the pipeline carries a valid bit per stage.
- Pipeline (fixed latency of 5 cycles from z_valid to accumulator update):
  - S1: p_i = z_i·w_i, 52-bit products, registered; z delayed alongside.
  - S2: y = sat_DW((p1+p2+p3+p4) >>> FRAC). Shift is arithmetic (floor).
  - S3: y2 = sat_DW((y·y) >>> FRAC).
  - S4: y3 = sat_DW((y2·y) >>> FRAC).
  - S5: acc_i += (z_i·y3) >>> FRAC, sign-extended to ACCW, wrapping. Wrap cannot occur within DW/FRAC limits for N=128.
- Saturation: sat_DW clamps to [−2^25, 2^25−1]. Any clamp sets sat_flag, which stays set until the next start.
- FINAL:
  - m_i = sat_DW(acc_i >>> LOG2_N).
  - w_new_i = sat_DW(m_i − 3·w_i), with 3·w_i computed at DW+2 bits. Saturation sets sat_flag.
- done timing: asserted exactly 7 cycles after the clock edge that accepts the N-th sample: 5 pipe + 1 FINAL + 1 DONE register.
- A start in the same cycle as done is ignored, because the state is DONE in that cycle. Next start is accepted from the following cycle.

Decomposition:
- Package fastica_pkg holds:
  - constants DW, FRAC, N_SAMPLES, LOG2_N, ACCW;
  - function sat_dw (wide signed → DW, plus an overflow bit);
  - state enum {IDLE, ACCUM, DRAIN, FINAL, DONE}.
- Sub-module ica_proj_cube: stages S1–S4.
  - Inputs: w, z, valid.
  - Outputs: delayed z, y3, valid, sat.
  - Instantiated once.
- The top holds the FSM, counter, accumulators and the FINAL arithmetic.

Test Plan:
- Basic update: w=(1048576,0,0,0); 128 samples z=(1048576,0,0,0) back-to-back → done 7 cycles after the last sample; w_out=(−2097152,0,0,0); sat_flag=0.
- Sign handling: same w; z1 alternating +1048576/−1048576, z2=524288 → y=±1.0 and y3=±1.0, so z1·y3=+1.0 and z2·y3 alternates ±0.5, mean 0 → w_out=(−2097152,0,0,0).
- Gaps and over-supply:
  - Random z_valid gaps → identical result to the back-to-back run.
  - 140 valid samples → only the first 128 are used; the last 12 have no effect.
- Saturation: w1=8388608 (8.0), z1=4194304 (4.0) for all samples → y clamps to 33554431; sat_flag=1 at done; w_out1 = sat(33554431 − 25165824) = 8388607.
- Control robustness:
  - start during ACCUM → ignored; busy stays 1; result unchanged.
  - rst_n low mid-ACCUM → busy, done, w_out and sat_flag all 0 immediately.
  - A fresh start after reset produces the correct result from the basic-update test.
